// File: rtl/tdmac_sequencer.sv
// tdmac_sequencer: drives a time-domain DTC/TDC multiplier as a multiply-accumulate
// engine. It takes a run of operands over a valid/ready stream and returns one
// accumulated sum per run over a valid/ready result port.
// Optional build macro: TDMAC_SATURATE_EN. When it is defined, the accumulator clamps
// at 2^ACC_W-1 on overflow. When it is undefined, the accumulator wraps.
// In both builds the sticky ovf flag is set on overflow.
module tdmac_sequencer #(
  parameter int DW       = 8,
  parameter int ACC_W    = 20,
  parameter int LEN_W    = 8,
  parameter int RST_CYC  = 1,
  parameter int CONV_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic [DW-1:0]    mul_in,
  output logic             mul_rst,
  input  logic [DW-1:0]    mul_out,
  output logic             busy,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_data,
  output logic             ovf
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    CONV   = 3'd3,
    ACCUM  = 3'd4,
    DONE   = 3'd5
  } state_t;

  // One shared counter times both the settle and conversion windows.
  localparam int CNT_MAX = (RST_CYC > CONV_CYC) ? RST_CYC : CONV_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYC - 1);

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    prod;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  // Unsigned add with a carry bit. The carry bit is the overflow indication.
  always_comb begin
    sum = {1'b0, acc} + {{(ACC_W + 1 - DW){1'b0}}, prod};
  end

  // These outputs are decoded only from the state register. No input has a
  // combinational path to any output.
  assign in_ready  = (state == LOAD);
  assign busy      = (state != IDLE);
  assign acc_valid = (state == DONE);
  assign acc_data  = acc;

  // Sequencer FSM. mul_rst is changed on the edge that enters or leaves CONV.
  // This keeps mul_rst registered and aligned exactly with the CONV state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      cnt       <= '0;
      mul_in    <= '0;
      mul_rst   <= 1'b1;
      prod      <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= len;
            acc       <= '0;
            ovf       <= 1'b0;
            state     <= (len != '0) ? LOAD : DONE;
          end
        end
        LOAD: begin
          if (in_valid) begin
            mul_in    <= in_data;
            remaining <= remaining - 1'b1;
            cnt       <= '0;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == RST_LAST) begin
            cnt     <= '0;
            mul_rst <= 1'b0;
            state   <= CONV;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CONV: begin
          if (cnt == CONV_LAST) begin
            cnt     <= '0;
            prod    <= mul_out;
            mul_rst <= 1'b1;
            state   <= ACCUM;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACCUM: begin
`ifdef TDMAC_SATURATE_EN
          // After the accumulator clamps at full scale, every later nonzero
          // product also carries out, so the accumulator stays clamped.
          acc <= sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
          acc <= sum[ACC_W-1:0];
`endif
          ovf   <= ovf | sum[ACC_W];
          state <= (remaining != '0) ? LOAD : DONE;
        end
        DONE: begin
          if (acc_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdmac_sequencer.sv
// Directed testbench for tdmac_sequencer.
// The multiplier is modelled as mul_out = mul_in while mul_rst is low, and 0 otherwise.
// The accumulator is narrowed to 10 bits so that five 255 operands overflow it.
module tb_tdmac_sequencer;

  localparam int DW = 8, ACC_W = 10, LEN_W = 8, RST_CYC = 1, CONV_CYC = 4;

  logic             clk, rst, start, in_valid, in_ready, mul_rst, busy;
  logic             acc_valid, acc_ready, ovf;
  logic [LEN_W-1:0] len;
  logic [DW-1:0]    in_data, mul_in, mul_out;
  logic [ACC_W-1:0] acc_data;

  int errors = 0;
  int checks = 0;
  int ops [8];

  tdmac_sequencer #(
    .DW(DW), .ACC_W(ACC_W), .LEN_W(LEN_W), .RST_CYC(RST_CYC), .CONV_CYC(CONV_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mul_in(mul_in), .mul_rst(mul_rst), .mul_out(mul_out),
    .busy(busy), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_data(acc_data), .ovf(ovf)
  );

  assign mul_out = mul_rst ? '0 : mul_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a run of n operands taken from ops[] and returns once acc_valid is seen.
  // cyc counts the clock edges from the start edge (that edge is 1) to acc_valid.
  // lowc counts the sampled cycles in which mul_rst was low.
  // Options:
  //   gap_after / gap_len: stall in_valid while in LOAD.
  //   poke: pulse start with len=7 during the first CONV.
  //   rst_mid: pulse reset in the second CONV and return early.
  task automatic do_run(input int n, input int gap_after, input int gap_len,
                        input bit poke, input bit rst_mid,
                        output int cyc, output int lowc);
    int idx, gap_rem, conv_seen;
    bit hs, prev_mr, poked;
    idx = 0; gap_rem = gap_len; conv_seen = 0; prev_mr = 1'b1; poked = 1'b0;
    cyc = 0; lowc = 0;
    len = LEN_W'(n);
    start = 1'b1;
    in_data = DW'(ops[0]);
    in_valid = (n > 0);
    tick();
    start = 1'b0;
    cyc = 1;
    while (1) begin
      if (!mul_rst) lowc++;
      if (acc_valid) break;
      if (cyc >= 400) begin
        checks++; errors++;
        $display("FAIL run_timeout: acc_valid=%0b after %0d cycles, required 1", acc_valid, cyc);
        break;
      end
      if (rst_mid && !mul_rst && prev_mr) begin
        conv_seen++;
        if (conv_seen == 2) begin
          rst = 1'b0;
          tick();
          rst = 1'b1;
          in_valid = 1'b0;
          return;
        end
      end
      prev_mr = mul_rst;
      if (poke && !mul_rst && !poked) begin
        start = 1'b1; len = 8'd7; poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (idx == gap_after && gap_rem > 0 && in_ready) begin
        in_valid = 1'b0;
        gap_rem--;
      end else begin
        in_valid = (idx < n);
      end
      hs = in_valid && in_ready;
      tick();
      cyc++;
      if (hs) idx++;
      in_data = DW'(ops[idx < 8 ? idx : 7]);
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    checks++; if (mul_in !== 8'd0) begin errors++; $display("FAIL reset_mul_in: got %0d want 0", mul_in); end
    checks++; if (mul_rst !== 1'b1) begin errors++; $display("FAIL reset_mul_rst: got %0b want 1", mul_rst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (acc_valid !== 1'b0) begin errors++; $display("FAIL reset_acc_valid: got %0b want 0", acc_valid); end
    checks++; if (acc_data !== 10'd0) begin errors++; $display("FAIL reset_acc_data: got %0d want 0", acc_data); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
    rst = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int cyc, lowc;
    ops[0] = 10; ops[1] = 20; ops[2] = 30;
    do_run(3, -1, 0, 1'b0, 1'b0, cyc, lowc);
    checks++; if (cyc !== 22) begin errors++; $display("FAIL basic_latency: got %0d want 22", cyc); end
    checks++; if (acc_data !== 10'd60) begin errors++; $display("FAIL basic_sum: got %0d want 60", acc_data); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %0b want 0", ovf); end
    checks++; if (lowc !== 12) begin errors++; $display("FAIL basic_mul_rst_low: got %0d want 12", lowc); end
    checks++; if (mul_in !== 8'd30) begin errors++; $display("FAIL basic_mul_in_hold: got %0d want 30", mul_in); end
    release_result();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: busy=%0b want 0", busy); end
    $display("test_basic: len=3 sum=%0d cycles=%0d", acc_data, cyc);
  endtask

  task automatic test_empty();
    int cyc, lowc;
    do_run(0, -1, 0, 1'b0, 1'b0, cyc, lowc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL empty_latency: got %0d want 1", cyc); end
    checks++; if (acc_data !== 10'd0) begin errors++; $display("FAIL empty_sum: got %0d want 0", acc_data); end
    release_result();
    $display("test_empty: len=0 cycles=%0d", cyc);
  endtask

  task automatic test_stall();
    int cyc, lowc;
    ops[0] = 3; ops[1] = 4;
    do_run(2, 1, 5, 1'b0, 1'b0, cyc, lowc);
    checks++; if (cyc !== 20) begin errors++; $display("FAIL stall_latency: got %0d want 20", cyc); end
    checks++; if (acc_data !== 10'd7) begin errors++; $display("FAIL stall_sum: got %0d want 7", acc_data); end
    checks++; if (lowc !== 8) begin errors++; $display("FAIL stall_conv_window: got %0d want 8", lowc); end
    release_result();
    $display("test_stall: len=2 gap=5 sum=%0d cycles=%0d", acc_data, cyc);
  endtask

  task automatic test_overflow();
    int cyc, lowc;
    logic [ACC_W-1:0] exp_acc;
`ifdef TDMAC_SATURATE_EN
    exp_acc = 10'd1023;
`else
    exp_acc = 10'd251;
`endif
    for (int i = 0; i < 5; i++) ops[i] = 255;
    do_run(5, -1, 0, 1'b0, 1'b0, cyc, lowc);
    checks++; if (acc_data !== exp_acc) begin errors++; $display("FAIL ovf_sum: got %0d want %0d", acc_data, exp_acc); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b want 1", ovf); end
    checks++; if (cyc !== 36) begin errors++; $display("FAIL ovf_latency: got %0d want 36", cyc); end
    release_result();
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky_idle: got %0b want 1", ovf); end
    $display("test_overflow: sum=%0d ovf=%0b", acc_data, ovf);
  endtask

  task automatic test_backpressure();
    int cyc, lowc;
    ops[0] = 9;
    do_run(1, -1, 0, 1'b0, 1'b0, cyc, lowc);
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      len = 8'd3;
      tick();
      checks++;
      if (acc_valid !== 1'b1 || acc_data !== 10'd9) begin
        errors++;
        $display("FAIL bp_hold_%0d: valid=%0b data=%0d want valid=1 data=9", i, acc_valid, acc_data);
      end
    end
    start = 1'b0;
    release_result();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_start_in_done: busy=%0b want 0", busy); end
    $display("test_backpressure: held 10 cycles data=9");
  endtask

  task automatic test_start_in_conv();
    int cyc, lowc;
    ops[0] = 5; ops[1] = 6;
    do_run(2, -1, 0, 1'b1, 1'b0, cyc, lowc);
    checks++; if (cyc !== 15) begin errors++; $display("FAIL conv_start_latency: got %0d want 15", cyc); end
    checks++; if (acc_data !== 10'd11) begin errors++; $display("FAIL conv_start_sum: got %0d want 11", acc_data); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL conv_start_ovf_cleared: got %0b want 0", ovf); end
    release_result();
    $display("test_start_in_conv: sum=%0d cycles=%0d", acc_data, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc, lowc;
    ops[0] = 2;
    do_run(1, -1, 0, 1'b0, 1'b0, cyc, lowc);
    acc_ready = 1'b1;
    start = 1'b1;
    len = 8'd1;
    tick();
    acc_ready = 1'b0;
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_exit: busy=%0b want 0", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_start_ignored: busy=%0b want 0", busy); end
    $display("test_back_to_back: start during DONE exit ignored");
  endtask

  task automatic test_reset_midrun();
    int cyc, lowc;
    for (int i = 0; i < 4; i++) ops[i] = 1;
    do_run(4, -1, 0, 1'b0, 1'b1, cyc, lowc);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b want 0", busy); end
    checks++; if (mul_rst !== 1'b1) begin errors++; $display("FAIL midrst_mul_rst: got %0b want 1", mul_rst); end
    checks++; if (acc_valid !== 1'b0) begin errors++; $display("FAIL midrst_acc_valid: got %0b want 0", acc_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %0b want 0", in_ready); end
    ops[0] = 7;
    do_run(1, -1, 0, 1'b0, 1'b0, cyc, lowc);
    checks++; if (acc_data !== 10'd7) begin errors++; $display("FAIL midrst_new_sum: got %0d want 7", acc_data); end
    checks++; if (cyc !== 8) begin errors++; $display("FAIL midrst_new_latency: got %0d want 8", cyc); end
    release_result();
    $display("test_reset_midrun: new run sum=%0d", acc_data);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; acc_ready = 1'b0;
    for (int i = 0; i < 8; i++) ops[i] = 0;
    test_reset();
    test_basic();
    test_empty();
    test_stall();
    test_overflow();
    test_backpressure();
    test_start_in_conv();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
